// File: rtl/uc_pila.sv
// uc_pila: control unit with a hardware return-address stack.
// Decodes the 6-bit opcode into datapath controls (combinational, no added
// latency) and manages call/ret through an internal LIFO of PC values.
// A stack overflow (call on full stack) or underflow (ret on empty stack)
// sets a sticky error flag and parks the unit in HALT until reset.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   opcode[5:0]     instruction bits [15:10]
//   z               zero flag
//   pc_next         PC+1, pushed as the return address on call
//   s_inc           1: next PC = PC+1, 0: next PC = jump target
//   s_inm           selects immediate as register-file write data
//   we3, wez        register-file / zero-flag write enables
//   op_alu[2:0]     ALU operation select
//   s_ret           1: next PC = ret_addr (overrides s_inc)
//   ret_addr        top-of-stack value (0 when stack empty)
//   pc_we           PC load enable
//   stack_ovf/unf   sticky stack error flags
//   sp              current stack occupancy
module uc_pila #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [5:0]                     opcode,
  input  logic                           z,
  input  logic [PC_WIDTH-1:0]            pc_next,
  output logic                           s_inc,
  output logic                           s_inm,
  output logic                           we3,
  output logic                           wez,
  output logic [2:0]                     op_alu,
  output logic                           s_ret,
  output logic [PC_WIDTH-1:0]            ret_addr,
  output logic                           pc_we,
  output logic                           stack_ovf,
  output logic                           stack_unf,
  output logic [$clog2(STACK_DEPTH):0]   sp
);

  localparam int unsigned AW  = $clog2(STACK_DEPTH);
  localparam int unsigned SPW = AW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state, state_nxt;
  logic [SPW-1:0]       sp_nxt;
  logic                 ovf_nxt, unf_nxt;
  logic [PC_WIDTH-1:0]  stack [STACK_DEPTH];
  logic [AW-1:0]        top_idx;

  logic is_alu, is_li, is_j, is_jz, is_jnz, is_call, is_ret;
  logic full, empty, ovf_evt, unf_evt, push, pop;

  // Opcode classes
  assign is_alu  = opcode[5];
  assign is_li   = (opcode[5:2] == 4'b0100);
  assign is_j    = (opcode == 6'b000100);
  assign is_jz   = (opcode == 6'b000010);
  assign is_jnz  = (opcode == 6'b000001);
  assign is_call = (opcode == 6'b000011);
  assign is_ret  = (opcode == 6'b000101);

  assign full  = (sp == SPW'(STACK_DEPTH));
  assign empty = (sp == '0);

  assign ovf_evt = (state == RUN) && is_call && full;
  assign unf_evt = (state == RUN) && is_ret && empty;
  assign push    = (state == RUN) && is_call && !full;
  assign pop     = (state == RUN) && is_ret && !empty;

  // Low bits of sp minus one; when sp==STACK_DEPTH the low bits are zero so
  // this wraps to STACK_DEPTH-1, which is exactly the top entry.
  assign top_idx  = sp[AW-1:0] - AW'(1);
  assign ret_addr = empty ? '0 : stack[top_idx];

  // Decode and next-state
  always_comb begin
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    op_alu    = 3'b000;
    s_ret     = 1'b0;
    pc_we     = 1'b0;
    state_nxt = state;
    sp_nxt    = sp;
    ovf_nxt   = stack_ovf;
    unf_nxt   = stack_unf;

    if (state == RUN) begin
      pc_we = !(ovf_evt || unf_evt);
      if (is_alu) begin
        we3    = 1'b1;
        wez    = 1'b1;
        op_alu = opcode[4:2];
      end
      if (is_li) begin
        s_inm = 1'b1;
        we3   = 1'b1;
      end
      if (is_j || is_call || (is_jz && z) || (is_jnz && !z))
        s_inc = 1'b0;
      if (pop)
        s_ret = 1'b1;

      if (push)
        sp_nxt = sp + SPW'(1);
      else if (pop)
        sp_nxt = sp - SPW'(1);

      if (ovf_evt) begin
        ovf_nxt   = 1'b1;
        state_nxt = HALT;
      end
      if (unf_evt) begin
        unf_nxt   = 1'b1;
        state_nxt = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      state     <= state_nxt;
      sp        <= sp_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Stack storage is not reset; the push is suppressed while reset is held
  // so a call overlapping reset leaves no trace.
  always_ff @(posedge clk) begin
    if (push && !reset)
      stack[sp[AW-1:0]] <= pc_next;
  end

endmodule

// File: tb/tb_uc_pila.sv
module tb_uc_pila;

  localparam int unsigned PCW   = 10;
  localparam int unsigned DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      opcode;
  logic            z;
  logic [PCW-1:0]  pc_next;
  logic            s_inc, s_inm, we3, wez, s_ret, pc_we, stack_ovf, stack_unf;
  logic [2:0]      op_alu;
  logic [PCW-1:0]  ret_addr;
  logic [3:0]      sp;

  int errors = 0;
  int checks = 0;

  uc_pila #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_next(pc_next),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op_alu(op_alu),
    .s_ret(s_ret), .ret_addr(ret_addr), .pc_we(pc_we),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .sp(sp)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_CALL = 6'b000011;
  localparam logic [5:0] OP_RET  = 6'b000101;
  localparam logic [5:0] OP_ALU7 = 6'b111111;
  localparam logic [5:0] OP_NOP  = 6'b000000;

  // {s_inc, s_inm, we3, wez, op_alu, s_ret, pc_we}
  typedef struct {
    logic [5:0] op;
    logic       zf;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {s_inc, s_inm, we3, wez, op_alu, s_ret, pc_we};
  endfunction

  // Advance past the next rising edge, landing 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    opcode = OP_NOP;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    tbl[0]  = '{6'b100010, 1'b0, 9'b1_0_1_1_000_0_1};
    tbl[1]  = '{6'b111111, 1'b1, 9'b1_0_1_1_111_0_1};
    tbl[2]  = '{6'b101100, 1'b0, 9'b1_0_1_1_011_0_1};
    tbl[3]  = '{6'b010011, 1'b0, 9'b1_1_1_0_000_0_1};
    tbl[4]  = '{6'b010000, 1'b1, 9'b1_1_1_0_000_0_1};
    tbl[5]  = '{6'b000100, 1'b0, 9'b0_0_0_0_000_0_1};
    tbl[6]  = '{6'b000010, 1'b0, 9'b1_0_0_0_000_0_1};
    tbl[7]  = '{6'b000010, 1'b1, 9'b0_0_0_0_000_0_1};
    tbl[8]  = '{6'b000001, 1'b0, 9'b0_0_0_0_000_0_1};
    tbl[9]  = '{6'b000001, 1'b1, 9'b1_0_0_0_000_0_1};
    tbl[10] = '{6'b000000, 1'b0, 9'b1_0_0_0_000_0_1};
    tbl[11] = '{6'b001000, 1'b1, 9'b1_0_0_0_000_0_1};
    tbl[12] = '{6'b011111, 1'b0, 9'b1_0_0_0_000_0_1};
    tbl[13] = '{6'b000110, 1'b0, 9'b1_0_0_0_000_0_1};

    reset = 1'b1; opcode = OP_NOP; z = 1'b0; pc_next = '0;
    #12;
    reset = 1'b0;
    #1;

    // Reset state
    chk("reset_sp", sp, 0);
    chk("reset_ovf", stack_ovf, 0);
    chk("reset_unf", stack_unf, 0);
    chk("reset_ret_addr", ret_addr, 0);

    // Decode table (RUN, empty stack; none of these touch the stack)
    for (int unsigned i = 0; i < 14; i++) begin
      opcode = tbl[i].op;
      z      = tbl[i].zf;
      #1;
      chk($sformatf("decode[%0d]", i), outs(), tbl[i].exp);
      tick();
      chk($sformatf("decode_sp[%0d]", i), sp, 0);
    end

    // Nested call/ret
    do_reset();
    opcode = OP_CALL; pc_next = 10'h005; z = 1'b0; #1;
    chk("call1_outs", outs(), 9'b0_0_0_0_000_0_1);
    tick();
    chk("call1_sp", sp, 1);
    chk("call1_top", ret_addr, 10'h005);
    pc_next = 10'h020; #1;
    tick();
    chk("call2_sp", sp, 2);
    chk("call2_top", ret_addr, 10'h020);
    opcode = OP_RET; pc_next = 10'h3FF; #1;
    chk("ret1_outs", outs(), 9'b1_0_0_0_000_1_1);
    chk("ret1_addr", ret_addr, 10'h020);
    tick();
    chk("ret1_sp", sp, 1);
    chk("ret2_addr", ret_addr, 10'h005);
    chk("ret2_s_ret", s_ret, 1);
    tick();
    chk("ret2_sp", sp, 0);
    chk("ret2_empty_addr", ret_addr, 0);
    chk("ret2_no_err", {stack_ovf, stack_unf}, 0);

    // Overflow
    do_reset();
    opcode = OP_CALL;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pc_next = PCW'(10'h100 + i);
      #1;
      chk($sformatf("fill_pc_we[%0d]", i), pc_we, 1);
      tick();
    end
    chk("full_sp", sp, DEPTH);
    chk("full_top", ret_addr, 10'h107);
    pc_next = 10'h2AA; #1;
    chk("ovf_pc_we", pc_we, 0);
    tick();
    chk("ovf_flag", stack_ovf, 1);
    chk("ovf_sp", sp, DEPTH);
    chk("ovf_top_kept", ret_addr, 10'h107);
    opcode = OP_ALU7; #1;
    chk("halt_alu_outs", outs(), 9'b1_0_0_0_000_0_0);
    opcode = 6'b010011; #1;
    chk("halt_li_outs", outs(), 9'b1_0_0_0_000_0_0);
    opcode = OP_RET; #1;
    chk("halt_ret_outs", outs(), 9'b1_0_0_0_000_0_0);
    tick();
    chk("halt_sp_frozen", sp, DEPTH);
    tick();
    chk("halt_ovf_sticky", stack_ovf, 1);

    // Underflow
    do_reset();
    opcode = OP_RET; #1;
    chk("unf_outs", outs(), 9'b1_0_0_0_000_0_0);
    tick();
    chk("unf_flag", stack_unf, 1);
    chk("unf_sp", sp, 0);
    opcode = 6'b100010; #1;
    chk("unf_halt_we3", we3, 0);
    do_reset();
    chk("unf_cleared", stack_unf, 0);
    opcode = 6'b100010; #1;
    chk("unf_run_again", outs(), 9'b1_0_1_1_000_0_1);
    chk("unf_rst_sp", sp, 0);

    // Reset between edges during a call
    do_reset();
    opcode = OP_CALL; pc_next = 10'h3AA; #1;
    tick();
    chk("mid_sp_before", sp, 1);
    pc_next = 10'h155;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_sp_async", sp, 0);
    chk("mid_addr_async", ret_addr, 0);
    tick();
    chk("mid_sp_held", sp, 0);
    @(negedge clk);
    reset = 1'b0;
    opcode = 6'b100010; #1;
    chk("mid_decode", outs(), 9'b1_0_1_1_000_0_1);
    tick();
    chk("mid_sp_after", sp, 0);
    opcode = OP_RET; #1;
    chk("mid_no_push", pc_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uc_pila.md
UC_PILA -- requirements
Module: uc_pila

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, width of program-counter values.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of return-address entries (power of 2, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port opcode  input  6  instruction bits [15:10].
REQ-006 SHALL have port z  input  1  zero flag from flag register.
REQ-007 SHALL have port pc_next  input  PC_WIDTH  current PC+1 (return address for call).
REQ-008 SHALL have outputs s_inc, s_inm, we3, wez  output  1 each  same meaning as the existing control unit.
REQ-009 SHALL have port op_alu  output  3  ALU operation select.
REQ-010 SHALL have port s_ret  output  1  1 selects ret_addr as next PC, overriding s_inc.
REQ-011 SHALL have port ret_addr  output  PC_WIDTH  top-of-stack value.
REQ-012 SHALL have port pc_we  output  1  PC load enable.
REQ-013 SHALL have ports stack_ovf, stack_unf  output  1 each  sticky error flags.
REQ-014 SHALL have port sp  output  $clog2(STACK_DEPTH)+1  current stack occupancy.

Function
REQ-015 Opcode map: 1xxxxx ALU (op_alu=opcode[4:2]); 0100xx load immediate; 000100 j; 000010 jz; 000001 jnz; 000011 call; 000101 ret; all other codes are nop.
REQ-016 In RUN, ALU: we3=1, wez=1, op_alu=opcode[4:2]; otherwise op_alu=0, wez=0.
REQ-017 In RUN, load immediate: s_inm=1, we3=1; s_inm=0 for every other opcode.
REQ-018 In RUN, s_inc=0 for j, call, jz with z=1, jnz with z=0; s_inc=1 otherwise.
REQ-019 Decode outputs SHALL be combinational from opcode, z and state; no added latency.
REQ-020 FSM states: RUN, HALT; RUN -> HALT on overflow or underflow event; HALT exits only via reset.
REQ-021 In RUN pc_we=1 except on the cycle an overflow or underflow is detected (pc_we=0).
REQ-022 call with sp<STACK_DEPTH: stack[sp] <= pc_next, sp <= sp+1 at clock edge; jumps via s_inc=0.
REQ-023 call with sp==STACK_DEPTH: no push, sp unchanged, stack_ovf <= 1, state <= HALT.
REQ-024 ret with sp>0: s_ret=1, s_inc=1, sp <= sp-1 at clock edge; PC loads ret_addr.
REQ-025 ret with sp==0: s_ret=0, no pop, stack_unf <= 1, state <= HALT.
REQ-026 ret_addr = stack[sp-1] when sp>0, else all zeros; combinational.
REQ-027 we3 and wez SHALL be 0 for call, ret, j, jz, jnz, nop.
REQ-028 In HALT: pc_we=0, we3=0, wez=0, s_inm=0, s_ret=0, s_inc=1, op_alu=0; stack and sp frozen.
REQ-029 Only one of push/pop occurs per cycle (opcode exclusive); sp never exceeds STACK_DEPTH or wraps below 0.
REQ-030 Error flags, once set, hold until reset.

Reset
REQ-031 reset=1 asynchronously forces state=RUN, sp=0, stack_ovf=0, stack_unf=0; stack contents need not be cleared.
REQ-032 Reset asserted mid-call or mid-ret SHALL discard the push/pop; after release, first cycle decodes normally with sp=0.

Verification
REQ-033 Reset, opcode=100010 (ALU op 000) -> we3=1, wez=1, op_alu=000, pc_we=1, sp=0.
REQ-034 call with pc_next=0x005, then call with pc_next=0x020, then ret, ret -> sp 1,2,1,0; ret_addr 0x020 then 0x005; s_ret=1 on each ret.
REQ-035 jz with z=0 -> s_inc=1; jz with z=1 -> s_inc=0; jnz inverse; we3=wez=0 both cases.
REQ-036 STACK_DEPTH+1 consecutive calls -> sp=STACK_DEPTH, last call: pc_we=0, stack_ovf=1, then HALT with we3=0 under any opcode.
REQ-037 ret after reset -> stack_unf=1, pc_we=0, HALT; then reset -> stack_unf=0, RUN, sp=0.
REQ-038 Assert reset between clock edges during a call -> sp=0 immediately, no push recorded.
